// File: rtl/uart_rx_fifo_controller.sv
// RX-side FIFO feeder: a one-byte holding register absorbs FIFO back-pressure, and
// bytes that arrive while it is occupied are dropped and counted. Optional: UART_RX_FRAME_CHECK_EN.
module uart_rx_fifo_controller #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx_enable,
  input  logic             i_dv,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_frame_err,
  input  logic             i_full,
  input  logic             i_clear,
  output logic             o_w_en,
  output logic [WIDTH-1:0] o_w_data,
  output logic             o_overflow,
  output logic [CNT_W-1:0] o_drop_count,
  output logic [CNT_W-1:0] o_frame_err_count
);
  // state  | meaning
  // IDLE   | holding register empty, waiting for a strobe
  // WRITE  | byte held, FIFO write issued next edge unless full
  // PEND   | byte held, waiting for FIFO to leave full
  // SETTLE | write in flight; a new byte may be captured
  typedef enum logic [1:0] {IDLE, WRITE, PEND, SETTLE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem;
  logic             accept, fe_ev, load, w_en_next, drop_ev;
  logic [CNT_W-1:0] drop_base, drop_next;

`ifdef UART_RX_FRAME_CHECK_EN
  assign accept = i_dv & ~i_frame_err;
  assign fe_ev  = i_dv & i_frame_err;
`else
  assign accept = i_dv;
  assign fe_ev  = i_frame_err & 1'b0;
`endif

  always_comb begin
    state_next = state;
    load       = 1'b0;
    w_en_next  = 1'b0;
    drop_ev    = 1'b0;
    case (state)
      IDLE, SETTLE: begin
        if (accept && i_rx_enable) begin
          load       = 1'b1;
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        drop_ev = accept;
        if (i_full) begin
          state_next = PEND;
        end else begin
          w_en_next  = 1'b1;
          state_next = SETTLE;
        end
      end
      PEND: begin
        drop_ev = accept;
        if (!i_full) state_next = WRITE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Clear takes effect first, so a same-cycle event lands on a zeroed counter.
  always_comb begin
    drop_base = i_clear ? '0 : o_drop_count;
    drop_next = (drop_ev && drop_base != CNT_MAX) ? drop_base + CNT_W'(1) : drop_base;
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state        <= IDLE;
      mem          <= '0;
      o_w_en       <= 1'b0;
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else begin
      state        <= state_next;
      o_w_en       <= w_en_next;
      o_drop_count <= drop_next;
      o_overflow   <= drop_ev | (o_overflow & ~i_clear);
      if (load) mem <= i_data;
    end
  end

  assign o_w_data = mem;

`ifdef UART_RX_FRAME_CHECK_EN
  logic [CNT_W-1:0] fe_base;

  assign fe_base = i_clear ? '0 : o_frame_err_count;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_frame_err_count <= '0;
    end else if (fe_ev && fe_base != CNT_MAX) begin
      o_frame_err_count <= fe_base + CNT_W'(1);
    end else begin
      o_frame_err_count <= fe_base;
    end
  end
`else
  assign o_frame_err_count = {CNT_W{fe_ev}};
`endif

endmodule

// File: tb/tb_uart_rx_fifo_controller.sv
// Bench for uart_rx_fifo_controller: a holding-slot model checked every cycle,
// plus directed scenarios with literal expectations. Counters built 2 bits wide.
module tb_uart_rx_fifo_controller;
  localparam int WIDTH = 8;
  localparam int CNT_W = 2;
  localparam int CMAX  = 3;
`ifdef UART_RX_FRAME_CHECK_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             i_reset = 1'b1;
  logic             i_rx_enable = 1'b0;
  logic             i_dv = 1'b0;
  logic [WIDTH-1:0] i_data = '0;
  logic             i_frame_err = 1'b0;
  logic             i_full = 1'b0;
  logic             i_clear = 1'b0;
  logic             o_w_en;
  logic [WIDTH-1:0] o_w_data;
  logic             o_overflow;
  logic [CNT_W-1:0] o_drop_count;
  logic [CNT_W-1:0] o_frame_err_count;

  uart_rx_fifo_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .i_reset(i_reset), .i_rx_enable(i_rx_enable), .i_dv(i_dv),
    .i_data(i_data), .i_frame_err(i_frame_err), .i_full(i_full), .i_clear(i_clear),
    .o_w_en(o_w_en), .o_w_data(o_w_data), .o_overflow(o_overflow),
    .o_drop_count(o_drop_count), .o_frame_err_count(o_frame_err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit armed = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a single slot that is either empty or holds a byte. A held byte is
  // written on an edge where the FIFO is not full, provided the previous edge
  // either captured it or also saw the FIFO not full.
  bit       m_held = 1'b0;
  bit       m_ready = 1'b0;
  bit [7:0] m_byte = '0;
  bit       m_w_en = 1'b0;
  bit       m_ovf = 1'b0;
  int       m_drop = 0;
  int       m_fe = 0;

  always @(posedge clk) begin
    bit acc, fe, drop;
    if (i_reset) begin
      m_held = 0; m_ready = 0; m_byte = '0; m_w_en = 0; m_ovf = 0; m_drop = 0; m_fe = 0;
    end else begin
      acc  = i_dv && !(FC && i_frame_err);
      fe   = FC && i_dv && i_frame_err;
      drop = 1'b0;
      m_w_en = 1'b0;
      if (m_held) begin
        drop = acc;
        if (m_ready && !i_full) begin
          m_w_en = 1'b1;
          m_held = 1'b0;
        end else begin
          m_ready = !i_full;
        end
      end else if (acc && i_rx_enable) begin
        m_held  = 1'b1;
        m_ready = 1'b1;
        m_byte  = i_data;
      end
      if (i_clear) begin
        m_drop = 0; m_fe = 0; m_ovf = 0;
      end
      if (drop) begin
        m_ovf = 1'b1;
        if (m_drop < CMAX) m_drop++;
      end
      if (fe && m_fe < CMAX) m_fe++;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("w_en", o_w_en, m_w_en);
      if (m_w_en) chk("w_data", o_w_data, m_byte);
      chk("overflow", o_overflow, m_ovf);
      chk("drop_count", o_drop_count, m_drop);
      chk("frame_err_count", o_frame_err_count, m_fe);
    end
  end

  byte unsigned wr_q[$];
  always @(negedge clk) if (!i_reset && o_w_en === 1'b1) wr_q.push_back(o_w_data);

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] d, input logic fe);
    i_dv = 1'b1; i_data = d; i_frame_err = fe;
    step(1);
    i_dv = 1'b0; i_frame_err = 1'b0;
  endtask

  task automatic pulse_clear();
    i_clear = 1'b1;
    step(1);
    i_clear = 1'b0;
  endtask

  initial begin
    int n;
    step(2);
    armed = 1'b1;
    chk("rst_w_en", o_w_en, 0);
    chk("rst_w_data", o_w_data, 0);
    chk("rst_drop", o_drop_count, 0);
    i_reset = 1'b0;
    i_rx_enable = 1'b1;

    // single byte, exact latency
    strobe(8'hA5, 1'b0);
    chk("lat_k", o_w_en, 0);
    step(1);
    chk("lat_k1_en", o_w_en, 1);
    chk("lat_k1_data", o_w_data, 8'hA5);
    step(1);
    chk("lat_k2_en", o_w_en, 0);
    chk("single_ovf", o_overflow, 0);
    step(2);

    // back-pressure
    i_full = 1'b1;
    strobe(8'h3C, 1'b0);
    n = wr_q.size();
    step(10);
    chk("bp_no_write", wr_q.size(), n);
    i_full = 1'b0;
    step(1);
    chk("bp_edge1", o_w_en, 0);
    step(1);
    chk("bp_edge2_en", o_w_en, 1);
    chk("bp_edge2_data", o_w_data, 8'h3C);
    step(4);
    chk("bp_once", wr_q.size(), n + 1);

    // overflow
    i_full = 1'b1;
    strobe(8'h11, 1'b0);
    step(1);
    strobe(8'h22, 1'b0);
    chk("ovf_flag", o_overflow, 1);
    chk("ovf_count", o_drop_count, 1);
    n = wr_q.size();
    i_full = 1'b0;
    step(6);
    chk("ovf_writes", wr_q.size(), n + 1);
    chk("ovf_byte", wr_q[$], 8'h11);

    // saturation and clear-with-event
    pulse_clear();
    chk("clr_count", o_drop_count, 0);
    chk("clr_ovf", o_overflow, 0);
    i_full = 1'b1;
    strobe(8'h40, 1'b0);
    for (int i = 0; i < 5; i++) strobe(8'h50 + 8'(i), 1'b0);
    chk("sat_count", o_drop_count, 3);
    i_clear = 1'b1;
    strobe(8'h60, 1'b0);
    i_clear = 1'b0;
    chk("clr_ev_count", o_drop_count, 1);
    chk("clr_ev_ovf", o_overflow, 1);
    i_full = 1'b0;
    step(5);
    chk("sat_held_byte", wr_q[$], 8'h40);

    // back-to-back via SETTLE
    pulse_clear();
    n = wr_q.size();
    strobe(8'h01, 1'b0);
    step(1);
    strobe(8'h02, 1'b0);
    step(5);
    chk("b2b_writes", wr_q.size(), n + 2);
    chk("b2b_first", wr_q[n], 8'h01);
    chk("b2b_second", wr_q[$], 8'h02);
    chk("b2b_no_drop", o_drop_count, 0);

    // disabled receiver ignores strobes
    i_rx_enable = 1'b0;
    n = wr_q.size();
    strobe(8'h77, 1'b0);
    step(4);
    chk("dis_no_write", wr_q.size(), n);
    i_rx_enable = 1'b1;

    // reset while pending
    i_full = 1'b1;
    strobe(8'h55, 1'b0);
    strobe(8'h56, 1'b0);
    step(3);
    i_reset = 1'b1;
    step(1);
    i_reset = 1'b0;
    i_full = 1'b0;
    chk("rstp_w_en", o_w_en, 0);
    chk("rstp_ovf", o_overflow, 0);
    n = wr_q.size();
    step(5);
    chk("rstp_no_write", wr_q.size(), n);
    chk("rstp_w_data", o_w_data, 0);

    // framing error
    strobe(8'hFF, 1'b1);
    step(4);
    if (FC) begin
      chk("fe_no_write", wr_q.size(), n);
      chk("fe_count", o_frame_err_count, 1);
    end else begin
      chk("fe_written", wr_q.size(), n + 1);
      chk("fe_byte", wr_q[$], 8'hFF);
      chk("fe_count_tied", o_frame_err_count, 0);
    end

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
